// File: rtl/tx10_bcd_fmt.sv
// Signed tenths-of-a-degree to sign + BCD digits + leading-zero blank mask (double-dabble, 1 bit/clk).
// done pulses W clocks after the accepting start edge; start is ignored while busy, never queued.
module tx10_bcd_fmt #(
  parameter int W  = 18,
  parameter int ND = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W-1:0]      tx10,
  output logic              busy,
  output logic              done,
  output logic              neg,
  output logic [4*ND-1:0]   digits,
  output logic [ND-1:0]     blank
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [ND-1:0] BLANK_RST = {{(ND-2){1'b1}}, 2'b00};

  typedef enum logic {IDLE, CONV} state_t;

  state_t            state_q;
  logic [4*ND-1:0]   bcd_q;
  logic [W-1:0]      mag_q;
  logic [CW-1:0]     cnt_q;
  logic              neg_r_q;
  logic              busy_q;
  logic              done_q;
  logic              neg_q;
  logic [4*ND-1:0]   digits_q;
  logic [ND-1:0]     blank_q;

  logic [4*ND-1:0]   bcd_d;
  logic [W-1:0]      mag_d;
  logic [W-1:0]      mag_in;
  logic [ND-1:0]     blank_d;

  // Two's-complement negate; the most negative input lands exactly on 2^(W-1).
  assign mag_in = tx10[W-1] ? (~tx10 + W'(1)) : tx10;

  // Add-3 on every nibble, then shift the magnitude MSB into the BCD chain.
  always_comb begin
    logic [3:0] nib;
    logic       carry;
    bcd_d = '0;
    nib   = '0;
    carry = mag_q[W-1];
    for (int i = 0; i < ND; i++) begin
      nib = bcd_q[4*i +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      bcd_d[4*i +: 4] = {nib[2:0], carry};
      carry = nib[3];
    end
    mag_d = {mag_q[W-2:0], 1'b0};
  end

  // Units and tenths always shown; higher digits blank while they and everything above are zero.
  always_comb begin
    logic zero_above;
    blank_d    = '0;
    zero_above = 1'b1;
    for (int i = ND - 1; i >= 2; i--) begin
      if (bcd_d[4*i +: 4] != 4'd0) zero_above = 1'b0;
      blank_d[i] = zero_above;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bcd_q    <= '0;
      mag_q    <= '0;
      cnt_q    <= '0;
      neg_r_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      neg_q    <= 1'b0;
      digits_q <= '0;
      blank_q  <= BLANK_RST;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            neg_r_q <= tx10[W-1];
            mag_q   <= mag_in;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          bcd_q <= bcd_d;
          mag_q <= mag_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) begin
            digits_q <= bcd_d;
            neg_q    <= neg_r_q;
            blank_q  <= blank_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign neg    = neg_q;
  assign digits = digits_q;
  assign blank  = blank_q;

endmodule

// File: tb/tb_tx10_bcd_fmt.sv
// Scoreboard bench for tx10_bcd_fmt: expectations queued at start, compared at each done pulse.
module tb_tx10_bcd_fmt;
  localparam int W  = 18;
  localparam int ND = 6;

  logic              clk;
  logic              rst;
  logic              start;
  logic [W-1:0]      tx10;
  logic              busy;
  logic              done;
  logic              neg;
  logic [4*ND-1:0]   digits;
  logic [ND-1:0]     blank;

  typedef struct {
    logic            neg;
    logic [4*ND-1:0] dig;
    logic [ND-1:0]   blk;
    int              cyc0;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;

  tx10_bcd_fmt #(.W(W), .ND(ND)) dut (
    .clk(clk), .rst(rst), .start(start), .tx10(tx10),
    .busy(busy), .done(done), .neg(neg), .digits(digits), .blank(blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input int v);
    exp_t e;
    int   m;
    logic z;
    m = (v < 0) ? -v : v;
    e.neg = (v < 0);
    e.dig = '0;
    for (int i = 0; i < ND; i++) begin
      e.dig[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    e.blk = '0;
    z = 1'b1;
    for (int i = ND - 1; i >= 2; i--) begin
      if (e.dig[4*i +: 4] != 4'd0) z = 1'b0;
      e.blk[i] = z;
    end
    e.cyc0 = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      done_cnt++;
      if (q.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        e = q.pop_front();
        check("latency", 32'(cyc - e.cyc0), 32'(W));
        check("neg", 32'(neg), 32'(e.neg));
        check("digits", 32'(digits), 32'(e.dig));
        check("blank", 32'(blank), 32'(e.blk));
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // Called at a negedge while the DUT is idle; the start is taken on the next posedge.
  task automatic launch(input int v);
    exp_t e;
    logic [31:0] vv;
    vv = v;
    e = model(v);
    e.cyc0 = cyc + 1;
    start = 1'b1;
    tx10 = vv[W-1:0];
    q.push_back(e);
    @(negedge clk);
    check("busy_after_start", 32'(busy), 32'd1);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      check("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("wait_done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    start = 1'b0;
    tx10 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_neg", 32'(neg), 32'd0);
    check("rst_digits", 32'(digits), 32'd0);
    check("rst_blank", 32'(blank), 32'b111100);
    rst = 1'b0;
    @(negedge clk);

    launch(500);
    drain();

    launch(-400);
    wait_done();
    launch(2120);
    drain();

    launch(0);
    drain();
    launch(-5);
    drain();

    launch(-131072);
    drain();
    launch(131071);
    drain();

    // Retrigger and input change mid-conversion must be ignored.
    d0 = done_cnt;
    launch(100);
    repeat (4) @(negedge clk);
    start = 1'b1;
    tx10 = 18'd999;
    @(negedge clk);
    start = 1'b0;
    tx10 = 18'd12345;
    drain();
    repeat (25) @(negedge clk);
    check("single_done", 32'(done_cnt - d0), 32'd1);
    check("hold_digits", 32'(digits), 32'h000100);

    // Reset mid-conversion discards the result.
    launch(777);
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    q.delete();
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    d0 = done_cnt;
    @(negedge clk);
    check("midrst_digits", 32'(digits), 32'd0);
    check("midrst_blank", 32'(blank), 32'b111100);
    check("midrst_neg", 32'(neg), 32'd0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("no_done_after_rst", 32'(done_cnt - d0), 32'd0);
    launch(777);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
